param_stream_fifo: RTL and testbench

PARAM_STREAM_FIFO -- requirements
Module: param_stream_fifo

---
 rtl/param_stream_fifo.sv | 179 +++++++++++++++++
 tb/tb_param_stream_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_stream_fifo.sv
// ----------------------------------------------------------------------------
// param_stream_fifo
//   Parameterised synchronous stream FIFO with registered status flags and
//   sticky error flags. FWFT=1 presents the head word with valid/ready
//   handshaking; FWFT=0 returns a registered word one cycle after each read
//   request.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset (highest priority)
//   flush        synchronous clear of pointers/count/output; errors kept
//   in_data      write payload
//   in_valid     write request
//   in_ready     space available (!full)
//   out_data     read payload
//   out_valid    out_data valid
//   out_ready    FWFT=1: head accepted; FWFT=0: read request
//   count        occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty   registered status flags
//   overflow, underflow                      sticky error flags
//   clr_err      clears the sticky error flags
// ----------------------------------------------------------------------------
module param_stream_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int AFULL_LVL  = (2**ADDR_WIDTH) - 4,
  parameter int AEMPTY_LVL = 4,
  parameter int FWFT       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LVL);
  localparam logic [ADDR_WIDTH:0]   AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LVL);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic wr;
  logic rd;

  // Both modes read only from a non-empty FIFO; a write into an empty FIFO
  // is never bypassed to the output in the same cycle.
  assign wr = in_valid && !full_q;
  assign rd = out_ready && !empty_q;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr) wptr_d = wptr_q + PTR_ONE;
      if (rd) rptr_d = rptr_q + PTR_ONE;
      count_d = count_q + (ADDR_WIDTH+1)'(wr) - (ADDR_WIDTH+1)'(rd);
    end

    // Flags come from the next-state count so they always agree with count.
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);

    // A new error event in the same cycle as clr_err keeps the flag set.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (in_valid && full_q)                  overflow_d  = 1'b1;
    if ((FWFT == 0) && out_ready && empty_q) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage has no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= in_data;
  end

  assign in_ready     = !full_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  if (FWFT != 0) begin : g_fwft
    // Head word is shown directly; forced to zero while empty so the output
    // is defined after reset/flush even though storage is not cleared.
    assign out_valid = !empty_q;
    assign out_data  = empty_q ? '0 : mem_q[rptr_q];
  end else begin : g_rdreq
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    always_comb begin
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      if (flush) begin
        out_data_d = '0;
      end else if (rd) begin
        out_valid_d = 1'b1;
        out_data_d  = mem_q[rptr_q];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else begin
        out_valid_q <= out_valid_d;
        out_data_q  <= out_data_d;
      end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
  end

endmodule

// File: tb/tb_param_stream_fifo.sv
// ----------------------------------------------------------------------------
// tb_param_stream_fifo
//   Drives one FWFT instance and one read-request instance with identical
//   stimulus and compares both against queue-based reference models.
// ----------------------------------------------------------------------------
module tb_param_stream_fifo;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;
  logic       clr_err;

  logic       in_ready1, out_valid1, full1, empty1, afull1, aempty1, ovf1, unf1;
  logic [7:0] out_data1;
  logic [5:0] count1;
  logic       in_ready0, out_valid0, full0, empty0, afull0, aempty0, ovf0, unf0;
  logic [7:0] out_data0;
  logic [5:0] count0;

  always #5 clk = ~clk;

  param_stream_fifo #(.FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready), .count(count1), .full(full1), .empty(empty1),
    .almost_full(afull1), .almost_empty(aempty1), .overflow(ovf1),
    .underflow(unf1), .clr_err(clr_err)
  );

  param_stream_fifo #(.FWFT(0)) u_rdreq (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
    .out_ready(out_ready), .count(count0), .full(full0), .empty(empty0),
    .almost_full(afull0), .almost_empty(aempty0), .overflow(ovf0),
    .underflow(unf0), .clr_err(clr_err)
  );

  // Reference model state
  logic [7:0] mq1[$];
  logic [7:0] mq0[$];
  logic       m_ovf1, m_ovf0, m_unf0, m_ov0;
  logic [7:0] m_od0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int n1, n0;
    n1 = mq1.size();
    n0 = mq0.size();
    chk("f1.count", 32'(count1), n1);
    chk("f1.full", 32'(full1), 32'(n1 == DEPTH));
    chk("f1.empty", 32'(empty1), 32'(n1 == 0));
    chk("f1.afull", 32'(afull1), 32'(n1 >= DEPTH - 4));
    chk("f1.aempty", 32'(aempty1), 32'(n1 <= 4));
    chk("f1.in_ready", 32'(in_ready1), 32'(n1 != DEPTH));
    chk("f1.out_valid", 32'(out_valid1), 32'(n1 > 0));
    if (n1 > 0) chk("f1.out_data", 32'(out_data1), 32'(mq1[0]));
    chk("f1.overflow", 32'(ovf1), 32'(m_ovf1));
    chk("f1.underflow", 32'(unf1), 32'(0));
    chk("f0.count", 32'(count0), n0);
    chk("f0.full", 32'(full0), 32'(n0 == DEPTH));
    chk("f0.empty", 32'(empty0), 32'(n0 == 0));
    chk("f0.afull", 32'(afull0), 32'(n0 >= DEPTH - 4));
    chk("f0.aempty", 32'(aempty0), 32'(n0 <= 4));
    chk("f0.in_ready", 32'(in_ready0), 32'(n0 != DEPTH));
    chk("f0.out_valid", 32'(out_valid0), 32'(m_ov0));
    if (m_ov0) chk("f0.out_data", 32'(out_data0), 32'(m_od0));
    chk("f0.overflow", 32'(ovf0), 32'(m_ovf0));
    chk("f0.underflow", 32'(unf0), 32'(m_unf0));
  endtask

  // One clock: drive inputs away from the edge, advance, update the models
  // from the pre-edge state, then compare everything.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy,
                       input logic fl, input logic ce, input logic rs);
    logic full_1, wr_1, rd_1, full_0, wr_0, rd_0, unf_evt;
    logic [7:0] head0;
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl; clr_err = ce; rst = rs;
    full_1  = (mq1.size() == DEPTH);
    wr_1    = iv && !full_1;
    rd_1    = ordy && (mq1.size() > 0);
    full_0  = (mq0.size() == DEPTH);
    wr_0    = iv && !full_0;
    rd_0    = ordy && (mq0.size() > 0);
    unf_evt = ordy && (mq0.size() == 0);
    head0   = (mq0.size() > 0) ? mq0[0] : 8'h00;
    @(posedge clk);
    #1;
    if (rs) begin
      mq1.delete(); mq0.delete();
      m_ovf1 = 1'b0; m_ovf0 = 1'b0; m_unf0 = 1'b0; m_ov0 = 1'b0; m_od0 = 8'h00;
    end else begin
      if (iv && full_1) m_ovf1 = 1'b1; else if (ce) m_ovf1 = 1'b0;
      if (iv && full_0) m_ovf0 = 1'b1; else if (ce) m_ovf0 = 1'b0;
      if (unf_evt) m_unf0 = 1'b1; else if (ce) m_unf0 = 1'b0;
      if (fl) begin
        mq1.delete(); mq0.delete();
        m_ov0 = 1'b0; m_od0 = 8'h00;
      end else begin
        if (rd_1) void'(mq1.pop_front());
        if (wr_1) mq1.push_back(d);
        m_ov0 = rd_0;
        if (rd_0) begin
          m_od0 = head0;
          void'(mq0.pop_front());
        end
        if (wr_0) mq0.push_back(d);
      end
    end
    check_all();
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       fl;
    logic       ce;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_count;
  } vec_t;

  vec_t vecs[9];

  initial begin
    rst = 1'b1; flush = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    out_ready = 1'b0; clr_err = 1'b0;

    // Back-to-back stream, then small occupancy moves and a flush with wr+rd.
    vecs[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1};
    vecs[1] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 1};
    vecs[2] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0};
    vecs[4] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44, 1};
    vecs[5] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44, 2};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1};
    vecs[7] = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0};

    // Reset state
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst.empty", 32'(empty1), 32'(1));
    chk("rst.aempty", 32'(aempty1), 32'(1));
    chk("rst.in_ready", 32'(in_ready1), 32'(1));
    chk("rst.out_data0", 32'(out_data0), 32'(0));

    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl, vecs[i].ce, 1'b0);
      chk($sformatf("vec%0d.out_valid", i), 32'(out_valid1), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d.out_data", i), 32'(out_data1), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d.count", i), 32'(count1), vecs[i].exp_count);
    end

    // Fill to full with no reads; almost_full from count 28 on.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 8'(i + 8'h80), 1'b0, 1'b0, 1'b0, 1'b0);
      chk("fill.afull", 32'(afull1), 32'(i + 1 >= 28));
    end
    chk("fill.full", 32'(full1), 32'(1));
    chk("fill.in_ready", 32'(in_ready1), 32'(0));
    chk("fill.count", 32'(count1), 32'(32));
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf.flag", 32'(ovf1), 32'(1));
    chk("ovf.count", 32'(count1), 32'(32));
    chk("ovf.head", 32'(out_data1), 32'(8'h80));

    // Full FIFO with continuous traffic; pointers wrap twice.
    for (int i = 0; i < 64; i++)
      cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);

    // Flush with ten stored words and a write pending; overflow is retained.
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("flush.count", 32'(count1), 32'(0));
    chk("flush.empty", 32'(empty1), 32'(1));
    chk("flush.out_valid", 32'(out_valid1), 32'(0));
    chk("flush.overflow", 32'(ovf1), 32'(1));

    // Reset mid-operation at count 17, then a fresh word comes out first.
    for (int i = 0; i < 17; i++)
      cycle(1'b1, 8'(i + 8'h40), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst.count", 32'(count1), 32'(17));
    cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("mid_rst.count", 32'(count1), 32'(0));
    chk("mid_rst.overflow", 32'(ovf1), 32'(0));
    chk("mid_rst.out_valid", 32'(out_valid1), 32'(0));
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst.head", 32'(out_data1), 32'(8'hA5));
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst.rd0_data", 32'(out_data0), 32'(8'hA5));
    chk("post_rst.rd0_valid", 32'(out_valid0), 32'(1));

    // Read request on empty: underflow only in read-request mode, then clear.
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("unf.set", 32'(unf0), 32'(1));
    chk("unf.out_valid", 32'(out_valid0), 32'(0));
    chk("unf.fwft_clear", 32'(unf1), 32'(0));
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("unf.cleared", 32'(unf0), 32'(0));
    // Clear coinciding with a new event keeps the flag set.
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("unf.clr_vs_evt", 32'(unf0), 32'(1));

    // Randomised traffic in alternating fill/drain phases.
    for (int i = 0; i < 3000; i++) begin
      int wp, rp;
      wp = ((i / 200) % 2 == 0) ? 75 : 30;
      rp = 100 - wp;
      cycle(1'($urandom_range(99) < wp), 8'($urandom),
            1'($urandom_range(99) < rp),
            1'($urandom_range(99) < 2),
            1'($urandom_range(99) < 4),
            1'($urandom_range(999) < 5));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
